// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer: CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7, CMD55/ACMD6.
// Drives the CMD line driver start handshake, checks responses, captures RCA and CCS.
module sd_init_seq #(
    parameter int ACMD41_RETRIES = 1000,
    parameter int GAP_CYCLES     = 8
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    output logic        ocmd_start,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    input  logic [75:0] iresp,
    input  logic        icmd_done,
    output logic [15:0] orca,
    output logic        ohcs,
    output logic        obusy,
    output logic        oready,
    output logic        oerror,
    output logic [2:0]  oerr_code
);

    localparam int CW = $clog2(ACMD41_RETRIES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT, ST_CHECK, ST_GAP, ST_READY, ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD8, STEP_CMD55_OP, STEP_ACMD41, STEP_CMD2,
        STEP_CMD3, STEP_CMD7, STEP_CMD55_BUS, STEP_ACMD6
    } step_t;

    state_t          state;
    step_t           step;
    logic [CW-1:0]   acmd41_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [5:0]      resp_idx;
    logic [31:0]     resp_arg;

    logic            chk_pass;
    logic            chk_last;
    step_t           chk_next;
    logic [2:0]      chk_code;

    // Response bits this sequencer never looks at.
    logic            unused_resp;
    assign unused_resp = ^{iresp[75:38], resp_arg[15:12]};

    function automatic logic [5:0] step_index(input step_t s);
        case (s)
            STEP_CMD8:      step_index = 6'd8;
            STEP_CMD55_OP:  step_index = 6'd55;
            STEP_ACMD41:    step_index = 6'd41;
            STEP_CMD2:      step_index = 6'd2;
            STEP_CMD3:      step_index = 6'd3;
            STEP_CMD7:      step_index = 6'd7;
            STEP_CMD55_BUS: step_index = 6'd55;
            default:        step_index = 6'd6;
        endcase
    endfunction

    function automatic logic [31:0] step_arg(input step_t s, input logic [15:0] rca);
        case (s)
            STEP_CMD8:      step_arg = 32'h0000_01AA;
            STEP_ACMD41:    step_arg = 32'h40FF_8000;
            STEP_CMD7:      step_arg = {rca, 16'h0000};
            STEP_CMD55_BUS: step_arg = {rca, 16'h0000};
            STEP_ACMD6:     step_arg = 32'h0000_0002;
            default:        step_arg = '0;
        endcase
    endfunction

    always_comb begin
        chk_pass = 1'b1;
        chk_last = 1'b0;
        chk_next = step;
        chk_code = 3'd0;
        case (step)
            STEP_CMD8: begin
                chk_pass = (resp_idx == 6'd8) && (resp_arg[11:0] == 12'h1AA);
                chk_next = STEP_CMD55_OP;
                chk_code = 3'd1;
            end
            STEP_CMD55_OP: begin
                chk_pass = (resp_idx == 6'd55);
                chk_next = STEP_ACMD41;
                chk_code = 3'd2;
            end
            STEP_ACMD41: begin
                chk_code = 3'd2;
                if (resp_arg[31]) begin
                    chk_next = STEP_CMD2;
                end else if (acmd41_cnt >= CW'(ACMD41_RETRIES - 1)) begin
                    chk_pass = 1'b0;
                end else begin
                    chk_next = STEP_CMD55_OP;
                end
            end
            STEP_CMD2: chk_next = STEP_CMD3;
            STEP_CMD3: begin
                chk_pass = (resp_idx == 6'd3);
                chk_next = STEP_CMD7;
                chk_code = 3'd4;
            end
            STEP_CMD7: begin
                chk_pass = (resp_idx == 6'd7);
                chk_next = STEP_CMD55_BUS;
                chk_code = 3'd5;
            end
            STEP_CMD55_BUS: begin
                chk_pass = (resp_idx == 6'd55);
                chk_next = STEP_ACMD6;
                chk_code = 3'd6;
            end
            default: begin
                chk_pass = (resp_idx == 6'd6);
                chk_last = 1'b1;
                chk_code = 3'd6;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= ST_IDLE;
            step       <= STEP_CMD8;
            acmd41_cnt <= '0;
            gap_cnt    <= '0;
            resp_idx   <= '0;
            resp_arg   <= '0;
            ocmd_start <= 1'b0;
            ocmd_index <= '0;
            ocmd_arg   <= '0;
            orca       <= '0;
            ohcs       <= 1'b0;
            obusy      <= 1'b0;
            oready     <= 1'b0;
            oerror     <= 1'b0;
            oerr_code  <= '0;
        end else begin
            ocmd_start <= 1'b0;
            case (state)
                ST_IDLE, ST_READY, ST_ERROR: begin
                    if (istart) begin
                        state      <= ST_ISSUE;
                        step       <= STEP_CMD8;
                        acmd41_cnt <= '0;
                        ocmd_start <= 1'b1;
                        ocmd_index <= step_index(STEP_CMD8);
                        ocmd_arg   <= step_arg(STEP_CMD8, '0);
                        orca       <= '0;
                        ohcs       <= 1'b0;
                        obusy      <= 1'b1;
                        oready     <= 1'b0;
                        oerror     <= 1'b0;
                        oerr_code  <= '0;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (icmd_done) begin
                        resp_idx <= iresp[37:32];
                        resp_arg <= iresp[31:0];
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (step == STEP_ACMD41) begin
                        if (resp_arg[31])
                            ohcs <= resp_arg[30];
                        else if (acmd41_cnt != '1)
                            acmd41_cnt <= acmd41_cnt + CW'(1);
                    end
                    if (step == STEP_CMD3 && chk_pass)
                        orca <= resp_arg[31:16];
                    if (!chk_pass) begin
                        state     <= ST_ERROR;
                        obusy     <= 1'b0;
                        oerror    <= 1'b1;
                        oerr_code <= chk_code;
                    end else if (chk_last) begin
                        state  <= ST_READY;
                        obusy  <= 1'b0;
                        oready <= 1'b1;
                    end else begin
                        state   <= ST_GAP;
                        step    <= chk_next;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state      <= ST_ISSUE;
                        ocmd_start <= 1'b1;
                        ocmd_index <= step_index(step);
                        ocmd_arg   <= step_arg(step, orca);
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
